// File: rtl/flex_pkg.sv
// Shared constants and helpers for the flex-sensor grab array.
// Used by flex_channel and flex_grab_array.
package flex_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 270000;
  localparam int DEFAULT_HOLD_CYCLES     = 27000000;

  // Pin level seen while the sensor is straight (not grabbing).
  function automatic logic idle_level(input int active_low);
    return (active_low != 0);
  endfunction

  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

endpackage

// File: rtl/flex_channel.sv
// One sensor channel: sync, debounce, pulses, hold flag.
// Optional grab counter under FLEX_GRAB_COUNT_EN.
module flex_channel
  import flex_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pin,
`ifdef FLEX_GRAB_COUNT_EN
  input  logic       grab_count_clr,
  output logic [7:0] grab_count,
`endif
  output logic       grabbing,
  output logic       grab_start,
  output logic       grab_end,
  output logic       grab_held,
  output logic       grabbing_nxt
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(HOLD_CYCLES + 1);
  localparam logic IDLE = idle_level(ACTIVE_LOW);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          grabbing_q, grabbing_d;
  logic          start_q, start_d;
  logic          end_q, end_d;
  logic          held_q, held_d;
  logic          raw_level;

  always_comb begin
    sync1_d    = pin;
    sync2_d    = sync1_q;
    raw_level  = sync2_q ^ IDLE;
    db_cnt_d   = '0;
    grabbing_d = grabbing_q;
    if (raw_level != grabbing_q) begin
      if (db_cnt_q == DB_LAST) grabbing_d = ~grabbing_q;
      else db_cnt_d = db_cnt_q + DW'(1);
    end
    start_d = grabbing_d & ~grabbing_q;
    end_d   = ~grabbing_d & grabbing_q;
    // The grab's first cycle is count 0, so held lands HOLD cycles later.
    hold_cnt_d = '0;
    if (grabbing_q && grabbing_d) begin
      if (hold_cnt_q == HOLD_MAX) hold_cnt_d = hold_cnt_q;
      else hold_cnt_d = hold_cnt_q + HW'(1);
    end
    held_d = grabbing_d && (hold_cnt_d == HOLD_MAX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= IDLE;
      sync2_q    <= IDLE;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      grabbing_q <= 1'b0;
      start_q    <= 1'b0;
      end_q      <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      grabbing_q <= grabbing_d;
      start_q    <= start_d;
      end_q      <= end_d;
      held_q     <= held_d;
    end
  end

  assign grabbing     = grabbing_q;
  assign grab_start   = start_q;
  assign grab_end     = end_q;
  assign grab_held    = held_q;
  assign grabbing_nxt = grabbing_d;

`ifdef FLEX_GRAB_COUNT_EN
  logic [7:0] gcnt_q, gcnt_d;

  // Counts the visible start pulse; a clear in that cycle wins.
  always_comb begin
    gcnt_d = gcnt_q;
    if (grab_count_clr) gcnt_d = '0;
    else if (start_q && (gcnt_q != 8'hFF)) gcnt_d = gcnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) gcnt_q <= '0;
    else gcnt_q <= gcnt_d;
  end

  assign grab_count = gcnt_q;
`endif

endmodule

// File: rtl/flex_grab_array.sv
// Multi-channel flex-sensor grab detector.
// Optional per-channel grab counters under FLEX_GRAB_COUNT_EN.
module flex_grab_array
  import flex_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_CH-1:0]   pin_in,
`ifdef FLEX_GRAB_COUNT_EN
  input  logic                grab_count_clr,
  output logic [NUM_CH*8-1:0] grab_count,
`endif
  output logic [NUM_CH-1:0]   grabbing,
  output logic [NUM_CH-1:0]   grab_start,
  output logic [NUM_CH-1:0]   grab_end,
  output logic [NUM_CH-1:0]   grab_held,
  output logic                any_grabbing
);

  logic [NUM_CH-1:0] grabbing_nxt;
  logic              any_q, any_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    flex_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .clk           (clk),
      .reset_n       (reset_n),
      .pin           (pin_in[i]),
`ifdef FLEX_GRAB_COUNT_EN
      .grab_count_clr(grab_count_clr),
      .grab_count    (grab_count[8*i +: 8]),
`endif
      .grabbing      (grabbing[i]),
      .grab_start    (grab_start[i]),
      .grab_end      (grab_end[i]),
      .grab_held     (grab_held[i]),
      .grabbing_nxt  (grabbing_nxt[i])
    );
  end

  always_comb begin
    any_d = |grabbing_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) any_q <= 1'b0;
    else any_q <= any_d;
  end

  assign any_grabbing = any_q;

endmodule

// File: tb/tb_flex_grab_array.sv
// Bench for flex_grab_array: directed table, hand sequences,
// random stimulus against a sample-history reference model.
module tb_flex_grab_array;

  localparam int NCH = 2;
  localparam int DB  = 4;
  localparam int HD  = 10;
  localparam int AL  = 1;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [NCH-1:0] pin_in = '1;
  logic [NCH-1:0] grabbing, grab_start, grab_end, grab_held;
  logic           any_grabbing;
`ifdef FLEX_GRAB_COUNT_EN
  logic             grab_count_clr = 1'b0;
  logic [NCH*8-1:0] grab_count;
`endif

  flex_grab_array #(
    .NUM_CH(NCH), .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES(HD), .ACTIVE_LOW(AL)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pin_in        (pin_in),
`ifdef FLEX_GRAB_COUNT_EN
    .grab_count_clr(grab_count_clr),
    .grab_count    (grab_count),
`endif
    .grabbing      (grabbing),
    .grab_start    (grab_start),
    .grab_end      (grab_end),
    .grab_held     (grab_held),
    .any_grabbing  (any_grabbing)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: grab level = pin sample from two edges earlier;
  // the state flips once the last DB levels all disagree with it.
  bit             pq [NCH][$];
  bit             rq [NCH][$];
  int             run [NCH];
  logic [NCH-1:0] m_g = '0, m_s = '0, m_e = '0, m_h = '0;

  task automatic m_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      pq[ch] = {1'b0, 1'b0};
      rq[ch].delete();
      run[ch] = 0;
    end
    m_g = '0; m_s = '0; m_e = '0; m_h = '0;
  endtask

  always @(posedge clk) begin : model
    bit lv, prev, flip;
    if (!reset_n) m_reset();
    else begin
      for (int ch = 0; ch < NCH; ch++) begin
        lv = pq[ch].pop_front();
        pq[ch].push_back(pin_in[ch] ^ (AL != 0));
        rq[ch].push_back(lv);
        if (rq[ch].size() > DB) void'(rq[ch].pop_front());
        flip = (rq[ch].size() == DB);
        for (int j = 0; j < rq[ch].size(); j++)
          if (rq[ch][j] == m_g[ch]) flip = 1'b0;
        prev = m_g[ch];
        if (flip) begin
          m_g[ch] = ~prev;
          rq[ch].delete();
        end
        m_s[ch] = m_g[ch] & ~prev;
        m_e[ch] = ~m_g[ch] & prev;
        if (!m_g[ch]) run[ch] = 0;
        else if (!prev) run[ch] = 0;
        else if (run[ch] < HD) run[ch]++;
        m_h[ch] = m_g[ch] && (run[ch] >= HD);
      end
    end
  end

  always @(negedge clk) begin
    chk("model", 32'({grabbing, grab_start, grab_end, grab_held, any_grabbing}),
        32'({m_g, m_s, m_e, m_h, |m_g}));
  end

  typedef struct {
    logic [1:0] pin;
    logic [1:0] g, s, e, h;
    logic       any;
  } vec_t;

  vec_t tbl [24];

  initial begin
    int k;
    logic [31:0] r;

    // Channel 0 press sampled at edge 0, release sampled at edge 17.
    for (int e = 0; e < 24; e++) begin
      tbl[e].pin = (e < 17) ? 2'b10 : 2'b11;
      tbl[e].g   = {1'b0, (e >= 5 && e < 22) ? 1'b1 : 1'b0};
      tbl[e].s   = {1'b0, (e == 5) ? 1'b1 : 1'b0};
      tbl[e].e   = {1'b0, (e == 22) ? 1'b1 : 1'b0};
      tbl[e].h   = {1'b0, (e >= 15 && e < 22) ? 1'b1 : 1'b0};
      tbl[e].any = (e >= 5 && e < 22);
    end

    pin_in = 2'b00;
    @(negedge clk);
    chk("reset_out", 32'({grabbing, grab_start, grab_end, grab_held, any_grabbing}), 0);
    @(negedge clk); #1;
    pin_in = 2'b11;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;

    for (int e = 0; e < 24; e++) begin
      pin_in = tbl[e].pin;
      @(negedge clk);
      chk($sformatf("tbl_%0d", e),
          32'({grabbing, grab_start, grab_end, grab_held, any_grabbing}),
          32'({tbl[e].g, tbl[e].s, tbl[e].e, tbl[e].h, tbl[e].any}));
      #1;
    end

    // Glitch on channel 1: three low samples never register.
    pin_in = 2'b01;
    repeat (3) @(negedge clk);
    #1;
    pin_in = 2'b11;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("glitch", 32'({grabbing[1], grab_start[1], any_grabbing}), 0);
    end
    #1;

    // Both channels pressed together.
    pin_in = 2'b00;
    k = 11;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (grab_start == 2'b11) begin
        k = i;
        r = 32'(any_grabbing);
        break;
      end
    end
    chk("simul_lat", 32'(k), 6);
    chk("simul_any", (k == 11) ? 32'd0 : r, 1);
    #1;
    pin_in = 2'b11;
    repeat (12) @(negedge clk);
    #1;

    // Reset at debounce count 2 with the pin held active.
    pin_in = 2'b10;
    repeat (4) @(negedge clk);
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid", 32'({grabbing, grab_start, grab_end, grab_held, any_grabbing}), 0);
    #1;
    reset_n = 1'b1;
    k = 11;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (grab_start[0]) begin
        k = i;
        break;
      end
    end
    chk("rst_lat", 32'(k), 6);
    #1;
    pin_in = 2'b11;
    repeat (12) @(negedge clk);
    #1;

    // Random levels with occasional resets; the model checks each cycle.
    repeat (250) begin
      r = $urandom;
      if ($urandom_range(0, 39) == 0) begin
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        reset_n = 1'b1;
      end
      pin_in = r[1:0];
      repeat ($urandom_range(1, 25)) @(negedge clk);
      #1;
    end
    pin_in = 2'b11;
    repeat (12) @(negedge clk);
    #1;

`ifdef FLEX_GRAB_COUNT_EN
    grab_count_clr = 1'b1;
    @(negedge clk);
    #1;
    grab_count_clr = 1'b0;
    repeat (300) begin
      pin_in = 2'b10;
      repeat (6) @(negedge clk);
      #1;
      pin_in = 2'b11;
      repeat (6) @(negedge clk);
      #1;
    end
    repeat (4) @(negedge clk);
    chk("cnt_sat", 32'(grab_count[7:0]), 255);
    chk("cnt_ch1", 32'(grab_count[15:8]), 0);
    #1;
    pin_in = 2'b10;
    k = 11;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (grab_start[0]) begin
        k = i;
        break;
      end
    end
    chk("clr_wait", 32'(k), 6);
    #1;
    grab_count_clr = 1'b1;
    @(negedge clk);
    #1;
    grab_count_clr = 1'b0;
    pin_in = 2'b11;
    repeat (10) @(negedge clk);
    chk("cnt_clr", 32'(grab_count[7:0]), 0);
    #1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
